// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit pipelined ALU and its issue/collect stage.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int OP_W    = 4;
    localparam int ALU_LAT = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   op_t;

    localparam op_t ALU_OP_ADD = 4'h0;
    localparam op_t ALU_OP_SUB = 4'h1;
    localparam op_t ALU_OP_AND = 4'h2;
    localparam op_t ALU_OP_OR  = 4'h3;
    localparam op_t ALU_OP_XOR = 4'h4;
    localparam op_t ALU_OP_NOP = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, pointers one bit wider than the address
// so full and empty are distinguished without a separate counter.
module sync_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_addr = '0;
            assign rd_addr = '0;
        end else begin : g_multi
            assign wr_addr = wr_ptr_q[AW-1:0];
            assign rd_addr = rd_ptr_q[AW-1:0];
        end
    endgenerate

    // Same slot but different lap bit means the writer is a full lap ahead.
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_addr == rd_addr);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_addr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_addr] <= wdata_i;
    end

    ast_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o));
    ast_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 3-stage ALU: buffers commands, issues one per cycle under
// response-slot credit, tracks them through the ALU latency and collects results.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = alu_pkg::ALU_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
);

    localparam int CMD_W = 2 * DATA_W + OP_W + TAG_W;
    localparam int RSP_W = DATA_W + TAG_W;
    localparam int CRD_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(RSP_DEPTH);
    localparam logic [CRD_W-1:0] CRD_ONE = 1;

    logic              cmd_push, cmd_full, cmd_empty;
    logic [CMD_W-1:0]  cmd_wdata, cmd_rdata;
    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;
    logic [TAG_W-1:0]  head_tag;

    logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RSP_W-1:0]  rsp_wdata, rsp_rdata;
    logic [RSP_W-1:0]  rsp_last_q, rsp_last_d;

    logic              issue;
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [ALU_LAT:0]  trk_vld_q, trk_vld_d;
    logic [TAG_W-1:0]  trk_tag_q [ALU_LAT+1];

    // Command side: cmd_ready depends only on registered FIFO state.
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_wdata = {cmd_a, cmd_b, cmd_op, cmd_tag};
    assign {head_a, head_b, head_op, head_tag} = cmd_rdata;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (cmd_push),
        .pop_i   (issue),
        .wdata_i (cmd_wdata),
        .rdata_o (cmd_rdata),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    // A slot in the response FIFO is claimed at issue, so a result always has room.
    assign issue = !cmd_empty && (credit_q != '0);

    always_comb begin
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = ALU_OP_NOP;
        if (issue) begin
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
        end
    end

    always_comb begin
        credit_d = credit_q;
        case ({issue, rsp_pop})
            2'b10:   credit_d = credit_q - CRD_ONE;
            2'b01:   credit_d = credit_q + CRD_ONE;
            default: credit_d = credit_q;
        endcase
    end

    assign trk_vld_d = {trk_vld_q[ALU_LAT-1:0], issue};

    // Response side: the last tracking stage lines up with the ALU result.
    assign rsp_push   = trk_vld_q[ALU_LAT];
    assign rsp_wdata  = {alu_result, trk_tag_q[ALU_LAT]};
    assign rsp_valid  = !rsp_empty;
    assign rsp_pop    = rsp_valid && rsp_ready;
    assign rsp_last_d = rsp_pop ? rsp_rdata : rsp_last_q;
    assign {rsp_data, rsp_tag} = rsp_empty ? rsp_last_q : rsp_rdata;

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (rsp_push),
        .pop_i   (rsp_pop),
        .wdata_i (rsp_wdata),
        .rdata_o (rsp_rdata),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= ALU_OP_NOP;
            trk_vld_q  <= '0;
            credit_q   <= CRD_MAX;
            rsp_last_q <= '0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            trk_vld_q  <= trk_vld_d;
            credit_q   <= credit_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // Tags are meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        trk_tag_q[0] <= head_tag;
        for (int i = 1; i <= ALU_LAT; i++) begin
            trk_tag_q[i] <= trk_tag_q[i-1];
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    ast_credit_max: assert property (@(posedge clk) disable iff (!reset)
        credit_q <= CRD_MAX);
    ast_rsp_room: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_push && rsp_full));

endmodule
